// File: rtl/seg_scan_ctrl_pkg.sv
// Purpose: shared state encoding and idle drive levels for the 7-segment scan controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LIT   = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  // Active-low drive: all ones means every segment / digit is dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] DIG_OFF = 8'hFF;

endpackage

// File: rtl/seg_scan_ctrl_hexto7segment.sv
// Purpose: hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input nibble.
module hexto7segment (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Lookup of the lit-segment pattern; a 0 bit turns the segment on.
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Purpose: time-multiplexed common-anode 7-segment scanner with frame-aligned host loads.
// Latency: outputs registered; a load shows from the first frame after the frame_done that commits it.
// Backpressure: load_ready = !pend_v; one load held until the next frame boundary (or any IDLE cycle).
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DWELL  = 50000,
  parameter int GUARD  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      blank_lz,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [4*DIGITS-1:0]       load_data,
  output logic [6:0]                seg_n,
  output logic [DIGITS-1:0]         dig_n,
  output logic [$clog2(DIGITS)-1:0] scan_idx,
  output logic                      frame_done
);

  localparam int IW   = $clog2(DIGITS);
  localparam int CMAX = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW   = $clog2(CMAX);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d, idx_inc;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4*DIGITS-1:0]  disp_reg, disp_d, pend_reg;
  logic                 pend_v;
  logic                 accept, commit, upper_nz, blank;
  logic [3:0]           sel_nib;
  logic [6:0]           dec_seg, seg_d;
  logic [DIGITS-1:0]    dig_d;
  logic                 fd_d;

  assign load_ready = !pend_v;
  assign scan_idx   = idx_q;
  assign idx_inc    = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

  // Loads land in pend_reg; they move to the display only at a frame boundary or while idle.
  assign accept = load_valid && !pend_v;
  assign commit = frame_done || (state_q == ST_IDLE);
  assign disp_d = (commit && pend_v) ? pend_reg : disp_reg;

  // Scan sequencing: dwell on a digit, optional dark gap, advance; enable low forces idle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_LIT;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_LIT: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (GUARD > 0) state_d = ST_GUARD;
          else           idx_d   = idx_inc;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_LIT;
          idx_d   = idx_inc;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  // Leading-zero detect: is any nibble at or above the next digit non-zero?
  always_comb begin
    upper_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx_d) && disp_d[4*i +: 4] != 4'h0) upper_nz = 1'b1;
    end
  end

  assign blank   = blank_lz && (idx_d != '0) && !upper_nz;
  assign sel_nib = disp_d[{idx_d, 2'b00} +: 4];

  hexto7segment u_dec (
    .hex (sel_nib),
    .seg (dec_seg)
  );

  // Next output image, computed from next state so outputs and state update together.
  always_comb begin
    seg_d = SEG_OFF;
    dig_d = DIG_OFF[DIGITS-1:0];
    fd_d  = 1'b0;
    if (state_d == ST_LIT) begin
      if (!blank) begin
        seg_d        = dec_seg;
        dig_d[idx_d] = 1'b0;
      end
      fd_d = (idx_d == IDX_LAST) && (cnt_d == DWELL_LAST);
    end
  end

  // State, display/pending registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      disp_reg   <= '0;
      pend_reg   <= '0;
      pend_v     <= 1'b0;
      seg_n      <= SEG_OFF;
      dig_n      <= DIG_OFF[DIGITS-1:0];
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      disp_reg   <= disp_d;
      seg_n      <= seg_d;
      dig_n      <= dig_d;
      frame_done <= fd_d;
      if (accept) begin
        pend_reg <= load_data;
        pend_v   <= 1'b1;
      end else if (commit) begin
        pend_v   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Purpose: directed self-checking bench for seg_scan_ctrl (DIGITS=4, DWELL=4, GUARD=1).
// Latency: outputs sampled on the falling edge, inputs driven there for the next rising edge.
// Backpressure: exercises load_ready drop, held offers and frame-boundary commit.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DWELL  = 4;
  localparam int GUARD  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        blank_lz = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = 16'h0;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic [1:0]  scan_idx;
  logic        frame_done;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .seg_n      (seg_n),
    .dig_n      (dig_n),
    .scan_idx   (scan_idx),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] dmask(input int i);
    logic [3:0] m;
    m    = 4'hF;
    m[i] = 1'b0;
    return m;
  endfunction

  // Check one cycle's outputs, then advance to the next falling edge.
  task automatic cyc(input string tag, input int idx, input logic [3:0] d,
                     input logic [6:0] s, input logic fd);
    chk({tag, "_dig"}, 32'(dig_n), 32'(d));
    chk({tag, "_seg"}, 32'(seg_n), 32'(s));
    chk({tag, "_idx"}, 32'(scan_idx), 32'(idx));
    chk({tag, "_fd"},  32'(frame_done), 32'(fd));
    @(negedge clk);
  endtask

  // One digit visit: DWELL lit cycles then one dark gap cycle.
  task automatic slot(input string tag, input int idx, input logic [3:0] d,
                      input logic [6:0] s, input logic last);
    for (int k = 0; k < DWELL; k++) cyc(tag, idx, d, s, last && (k == DWELL - 1));
    cyc({tag, "_gap"}, idx, 4'hF, 7'h7F, 1'b0);
  endtask

  // Whole frame; bm marks blanked digits.
  task automatic frame(input string tag, input logic [3:0] bm,
                       input logic [6:0] s3, input logic [6:0] s2,
                       input logic [6:0] s1, input logic [6:0] s0);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 4; i++)
      slot($sformatf("%s_d%0d", tag, i), i, bm[i] ? 4'hF : dmask(i),
           bm[i] ? 7'h7F : s[i], i == 3);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_seg",   32'(seg_n),      32'h7F);
    chk("rst_dig",   32'(dig_n),      32'hF);
    chk("rst_idx",   32'(scan_idx),   32'd0);
    chk("rst_fd",    32'(frame_done), 32'd0);

    // 1: load 12AF while idle, then scan
    rst_n = 1'b1; load_valid = 1'b1; load_data = 16'h12AF;
    @(negedge clk);
    chk("s1_ready_low", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    @(negedge clk);
    chk("s1_ready_high", 32'(load_ready), 32'd1);
    enable = 1'b1;
    @(negedge clk);
    frame("f1", 4'b0000, 7'h79, 7'h24, 7'h08, 7'h0E);

    // 2/3: mid-frame load at idx 1, then a held second offer
    slot("f2_d0", 0, 4'b1110, 7'h0E, 1'b0);
    load_valid = 1'b1; load_data = 16'h0003;
    cyc("f2_d1", 1, 4'b1101, 7'h08, 1'b0);
    chk("s2_ready_low", 32'(load_ready), 32'd0);
    load_data = 16'h0042;
    for (int k = 1; k < DWELL; k++) cyc("f2_d1", 1, 4'b1101, 7'h08, 1'b0);
    cyc("f2_d1_gap", 1, 4'hF, 7'h7F, 1'b0);
    slot("f2_d2", 2, 4'b1011, 7'h24, 1'b0);
    for (int k = 0; k < DWELL; k++) cyc("f2_d3", 3, 4'b0111, 7'h79, k == DWELL - 1);
    chk("s2_ready_after_commit", 32'(load_ready), 32'd1);
    cyc("f2_d3_gap", 3, 4'hF, 7'h7F, 1'b0);
    chk("s3_held_accepted", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    frame("f3", 4'b0000, 7'h40, 7'h40, 7'h40, 7'h30);
    chk("s3_ready_after_commit", 32'(load_ready), 32'd1);
    frame("f4", 4'b0000, 7'h40, 7'h40, 7'h19, 7'h24);

    // 4: leading-zero blanking (0042 under blanking, then 0050, then 0000)
    blank_lz = 1'b1; load_valid = 1'b1; load_data = 16'h0050;
    cyc("f5_d0", 0, 4'b1110, 7'h24, 1'b0);
    load_valid = 1'b0;
    for (int k = 1; k < DWELL; k++) cyc("f5_d0", 0, 4'b1110, 7'h24, 1'b0);
    cyc("f5_d0_gap", 0, 4'hF, 7'h7F, 1'b0);
    slot("f5_d1", 1, 4'b1101, 7'h19, 1'b0);
    slot("f5_d2", 2, 4'hF, 7'h7F, 1'b0);
    slot("f5_d3", 3, 4'hF, 7'h7F, 1'b1);
    load_valid = 1'b1; load_data = 16'h0000;
    cyc("f6_d0", 0, 4'b1110, 7'h40, 1'b0);
    load_valid = 1'b0;
    for (int k = 1; k < DWELL; k++) cyc("f6_d0", 0, 4'b1110, 7'h40, 1'b0);
    cyc("f6_d0_gap", 0, 4'hF, 7'h7F, 1'b0);
    slot("f6_d1", 1, 4'b1101, 7'h12, 1'b0);
    slot("f6_d2", 2, 4'hF, 7'h7F, 1'b0);
    slot("f6_d3", 3, 4'hF, 7'h7F, 1'b1);
    frame("f7", 4'b1110, 7'h7F, 7'h7F, 7'h7F, 7'h40);

    // 5: drop enable during the gap after digit 2
    slot("f8_d0", 0, 4'b1110, 7'h40, 1'b0);
    slot("f8_d1", 1, 4'hF, 7'h7F, 1'b0);
    for (int k = 0; k < DWELL; k++) cyc("f8_d2", 2, 4'hF, 7'h7F, 1'b0);
    enable = 1'b0;
    cyc("f8_d2_gap", 2, 4'hF, 7'h7F, 1'b0);
    cyc("s5_idle", 0, 4'hF, 7'h7F, 1'b0);
    enable = 1'b1; blank_lz = 1'b0;
    cyc("s5_idle2", 0, 4'hF, 7'h7F, 1'b0);

    // Re-enabled: full dwell on digit 0; a load goes pending meanwhile
    load_valid = 1'b1; load_data = 16'h9999;
    cyc("f9_d0", 0, 4'b1110, 7'h40, 1'b0);
    load_valid = 1'b0;
    chk("s6_pend", 32'(load_ready), 32'd0);
    for (int k = 1; k < DWELL; k++) cyc("f9_d0", 0, 4'b1110, 7'h40, 1'b0);
    cyc("f9_d0_gap", 0, 4'hF, 7'h7F, 1'b0);
    cyc("f9_d1", 1, 4'b1101, 7'h40, 1'b0);
    cyc("f9_d1", 1, 4'b1101, 7'h40, 1'b0);

    // 6: asynchronous reset mid-lit with a pending load
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_dig",   32'(dig_n),      32'hF);
    chk("s6_rst_seg",   32'(seg_n),      32'h7F);
    chk("s6_rst_ready", 32'(load_ready), 32'd1);
    chk("s6_rst_idx",   32'(scan_idx),   32'd0);
    chk("s6_rst_fd",    32'(frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("s6_after_rst", 0, 4'hF, 7'h7F, 1'b0);
    frame("f10", 4'b0000, 7'h40, 7'h40, 7'h40, 7'h40);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
